dec2bin_duty: RTL and testbench

//  Sequential BCD-to-binary converter (reverse double-dabble) for duty-cycle entry.

---
 rtl/duty_conv_pkg.sv | 18 +
 rtl/bcd_digit_adj.sv | 16 +
 rtl/dec2bin_duty.sv | 142 ++++++++++++++
 tb/tb_dec2bin_duty.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_conv_pkg.sv
// Shared constants and FSM state encoding for the BCD-to-binary duty converter.
package duty_conv_pkg;

    localparam int unsigned BCD_DIGIT_W  = 4;
    localparam int unsigned MAX_DUTY_DEF = 100;

    // Reverse double-dabble correction: a digit >= 8 after a right shift gets 3 removed
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_SUB    = 4'd3;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT  = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } duty_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational per-digit correction step: if the digit is >= 8, subtract 3 (no borrow out).
module bcd_digit_adj
    import duty_conv_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_ADJ_THRESH) begin
            digit_o = digit_i - BCD_ADJ_SUB;
        end
    end

endmodule

// File: rtl/dec2bin_duty.sv
// Sequential packed-BCD to binary duty converter, one shift+correct step per clock.
// Optional DUTY_CLAMP_EN: results above MAX_DUTY (or overflowing) saturate to MAX_DUTY.
module dec2bin_duty
    import duty_conv_pkg::*;
#(
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned BIN_W    = 7,
    parameter int unsigned MAX_DUTY = MAX_DUTY_DEF
) (
    input  logic                          clk_50M,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                          busy,
    output logic                          done,
    output logic [BIN_W-1:0]              bin_out,
    output logic                          ovf,
    output logic                          err
);

    localparam int unsigned BcdW = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CntW = $clog2(BIN_W + 1);

    if (MAX_DUTY >= (64'd1 << BIN_W)) begin : g_bad_max_duty
        $error("MAX_DUTY must be representable in BIN_W bits");
    end

    duty_state_e       state_q;
    logic [BcdW-1:0]   bcd_q;
    logic [BIN_W-1:0]  bin_q;
    logic [CntW-1:0]   cnt_q;
    logic              err_pend_q;
    logic              busy_q;
    logic              done_q;
    logic [BIN_W-1:0]  bin_out_q;
    logic              ovf_q;
    logic              err_q;

    logic [BcdW-1:0]   bcd_shift;
    logic [BcdW-1:0]   bcd_adj;
    logic [BIN_W-1:0]  bin_shift;
    logic              bad_digit;
    logic              residual;

    // The whole {bcd,bin} register moves right; the bcd LSB becomes the new bin MSB
    assign bcd_shift = {1'b0, bcd_q[BcdW-1:1]};
    assign bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};
    assign residual  = (bcd_q != '0);

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
                bad_digit = 1'b1;
            end
        end
    end

`ifdef DUTY_CLAMP_EN
    localparam logic [BIN_W-1:0] MaxDutyW = BIN_W'(MAX_DUTY);
    logic              clamp;
    logic [BIN_W-1:0]  bin_final;
    assign clamp     = residual || (bin_q > MaxDutyW);
    assign bin_final = clamp ? MaxDutyW : bin_q;
`else
    logic              clamp;
    logic [BIN_W-1:0]  bin_final;
    assign clamp     = residual;
    assign bin_final = bin_q;
`endif

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bin_out_q  <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        bcd_q <= bcd_in;
                        bin_q <= '0;
                        if (bad_digit) begin
                            err_pend_q <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            err_pend_q <= 1'b0;
                            cnt_q      <= CntW'(BIN_W);
                            busy_q     <= 1'b1;
                            state_q    <= StShift;
                        end
                    end
                end
                StShift: begin
                    bcd_q <= bcd_adj;
                    bin_q <= bin_shift;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                    if (err_pend_q) begin
                        bin_out_q <= '0;
                        ovf_q     <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        bin_out_q <= bin_final;
                        ovf_q     <= clamp;
                        err_q     <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_out_q;
    assign ovf     = ovf_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dec2bin_duty.sv
// Self-checking bench for dec2bin_duty against an arithmetic decimal reference model.
module tb_dec2bin_duty;

    localparam int DIGITS   = 3;
    localparam int BIN_W    = 7;
    localparam int MAX_DUTY = 100;

    logic        clk_50M = 1'b0;
    logic        rst     = 1'b0;
    logic        start   = 1'b0;
    logic [11:0] bcd_in  = '0;
    logic        busy;
    logic        done;
    logic [6:0]  bin_out;
    logic        ovf;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    dec2bin_duty #(
        .DIGITS   (DIGITS),
        .BIN_W    (BIN_W),
        .MAX_DUTY (MAX_DUTY)
    ) dut (
        .clk_50M (clk_50M),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .ovf     (ovf),
        .err     (err)
    );

    always #5 clk_50M = ~clk_50M;

    // Decimal value of the digits, then the result rules applied with plain arithmetic
    function automatic void ref_conv(input logic [11:0] v, output logic [6:0] b,
                                     output logic o, output logic e);
        int val;
        int d;
        val = 0;
        e   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(v[i*4 +: 4]);
            if (d > 9) e = 1'b1;
            val = val * 10 + d;
        end
        if (e) begin
            b = '0;
            o = 1'b0;
        end else begin
            o = (val >= (1 << BIN_W));
            b = 7'(val % (1 << BIN_W));
`ifdef DUTY_CLAMP_EN
            if (o || val > MAX_DUTY) begin
                b = 7'(MAX_DUTY);
                o = 1'b1;
            end
`endif
        end
    endfunction

    task automatic run_conv(input logic [11:0] v, output int lat, output int bcnt,
                            output logic [6:0] b, output logic o, output logic e);
        @(negedge clk_50M);
        start  = 1'b1;
        bcd_in = v;
        @(posedge clk_50M);
        #1;
        start  = 1'b0;
        bcd_in = 12'($urandom);
        lat  = -1;
        bcnt = 0;
        b    = '0;
        o    = 1'b0;
        e    = 1'b0;
        @(negedge clk_50M);
        if (busy) bcnt++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_50M);
            @(negedge clk_50M);
            if (done) begin
                lat = k;
                b   = bin_out;
                o   = ovf;
                e   = err;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        start  = 1'b1;
        bcd_in = 12'h050;
        repeat (3) @(negedge clk_50M);
        n_tests++;
        if ({busy, done, bin_out, ovf, err} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b bin=%0d ovf=%b err=%b, want all 0",
                     busy, done, bin_out, ovf, err);
        end
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk_50M);
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [11:0] vec [8] = '{12'h050, 12'h127, 12'h128, 12'h0A5,
                                 12'h000, 12'h101, 12'h999, 12'h009};
        logic [6:0] b, eb;
        logic o, e, eo, ee;
        int lat, bcnt, elat, ebcnt;
        for (int i = 0; i < 8; i++) begin
            ref_conv(vec[i], eb, eo, ee);
            elat  = ee ? 1 : 8;
            ebcnt = ee ? 0 : 7;
            run_conv(vec[i], lat, bcnt, b, o, e);
            n_tests++;
            if (lat !== elat || bcnt !== ebcnt) begin
                n_fail++;
                $display("FAIL directed_timing %h: got latency=%0d busy_cycles=%0d, want %0d %0d",
                         vec[i], lat, bcnt, elat, ebcnt);
            end
            n_tests++;
            if (b !== eb || o !== eo || e !== ee) begin
                n_fail++;
                $display("FAIL directed_result %h: got bin=%0d ovf=%b err=%b, want %0d %b %b",
                         vec[i], b, o, e, eb, eo, ee);
            end
            @(posedge clk_50M);
            @(negedge clk_50M);
            n_tests++;
            if (done !== 1'b0 || bin_out !== eb || ovf !== eo || err !== ee) begin
                n_fail++;
                $display("FAIL directed_hold %h: got done=%b bin=%0d ovf=%b err=%b, want 0 %0d %b %b",
                         vec[i], done, bin_out, ovf, err, eb, eo, ee);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] v;
        logic [6:0] b, eb, prev_b;
        logic o, e, eo, ee, prev_o, prev_e;
        int lat, bcnt;
        prev_b = bin_out;
        prev_o = ovf;
        prev_e = err;
        for (int i = 0; i < 40; i++) begin
            v = '0;
            for (int d = 0; d < DIGITS; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) v[$urandom_range(0, 2)*4 +: 4] = 4'($urandom_range(10, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk_50M);
            n_tests++;
            if (bin_out !== prev_b || ovf !== prev_o || err !== prev_e) begin
                n_fail++;
                $display("FAIL random_hold: got bin=%0d ovf=%b err=%b, want %0d %b %b",
                         bin_out, ovf, err, prev_b, prev_o, prev_e);
            end
            ref_conv(v, eb, eo, ee);
            run_conv(v, lat, bcnt, b, o, e);
            n_tests++;
            if (lat !== (ee ? 1 : 8) || b !== eb || o !== eo || e !== ee) begin
                n_fail++;
                $display("FAIL random_conv %h: got lat=%0d bin=%0d ovf=%b err=%b, want %0d %0d %b %b",
                         v, lat, b, o, e, ee ? 1 : 8, eb, eo, ee);
            end
            prev_b = eb;
            prev_o = eo;
            prev_e = ee;
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        logic [6:0] got;
        ndone = 0;
        got   = '0;
        @(negedge clk_50M);
        start  = 1'b1;
        bcd_in = 12'h099;
        @(posedge clk_50M);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_50M);
            #1;
            start  = (k == 2 || k == 7);
            bcd_in = 12'h033;
            @(negedge clk_50M);
            if (done) begin
                ndone++;
                got = bin_out;
            end
        end
        start = 1'b0;
        n_tests++;
        if (ndone !== 1 || got !== 7'd99) begin
            n_fail++;
            $display("FAIL ignore_start: got dones=%0d bin=%0d, want 1 99", ndone, got);
        end
    endtask

    task automatic test_reset_midflight();
        int ndone, lat, bcnt;
        logic [6:0] b;
        logic o, e;
        @(negedge clk_50M);
        start  = 1'b1;
        bcd_in = 12'h075;
        @(posedge clk_50M);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk_50M);
        #1;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, bin_out, ovf, err} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_async: got busy=%b done=%b bin=%0d ovf=%b err=%b, want all 0",
                     busy, done, bin_out, ovf, err);
        end
        repeat (2) @(negedge clk_50M);
        rst   = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk_50M);
            if (done || busy) ndone++;
        end
        n_tests++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL reset_discard: got %0d busy/done cycles, want 0", ndone);
        end
        run_conv(12'h000, lat, bcnt, b, o, e);
        n_tests++;
        if (lat !== 8 || b !== 7'd0 || o !== 1'b0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_recover: got lat=%0d bin=%0d ovf=%b err=%b, want 8 0 0 0",
                     lat, b, o, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] v;
        logic [6:0] eb;
        logic eo, ee;
        int prev_k, ndone;
        v = '0;
        for (int d = 0; d < DIGITS; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
        ref_conv(v, eb, eo, ee);
        prev_k = 0;
        ndone  = 0;
        @(negedge clk_50M);
        start  = 1'b1;
        bcd_in = v;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_50M);
            @(negedge clk_50M);
            if (done) begin
                ndone++;
                n_tests++;
                if ((k - prev_k) !== 9 || bin_out !== eb || ovf !== eo || err !== ee) begin
                    n_fail++;
                    $display("FAIL back_to_back %h: got gap=%0d bin=%0d ovf=%b err=%b, want 9 %0d %b %b",
                             v, k - prev_k, bin_out, ovf, err, eb, eo, ee);
                end
                prev_k = k;
            end
        end
        start = 1'b0;
        n_tests++;
        if (ndone !== 4) begin
            n_fail++;
            $display("FAIL back_to_back_count: got %0d dones, want 4", ndone);
        end
        repeat (12) @(negedge clk_50M);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_midflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
